// File: rtl/fnd_pkg.sv
// Shared types and glyph constants for the FND scan path.
// Active-low segment order is {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        GUARD = 1'b1
    } state_e;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [3:0] COM_OFF = 4'b1111;

    function automatic logic [3:0] com_sel(input logic [1:0] idx);
        com_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF[6:0];
        unique case (i_code)
            4'h0: o_seg = SEG_0[6:0];
            4'h1: o_seg = SEG_1[6:0];
            4'h2: o_seg = SEG_2[6:0];
            4'h3: o_seg = SEG_3[6:0];
            4'h4: o_seg = SEG_4[6:0];
            4'h5: o_seg = SEG_5[6:0];
            4'h6: o_seg = SEG_6[6:0];
            4'h7: o_seg = SEG_7[6:0];
            4'h8: o_seg = SEG_8[6:0];
            4'h9: o_seg = SEG_9[6:0];
            4'hA: o_seg = SEG_A[6:0];
            4'hB: o_seg = SEG_B[6:0];
            4'hC: o_seg = SEG_C[6:0];
            4'hD: o_seg = SEG_D[6:0];
            4'hE: o_seg = SEG_E[6:0];
            4'hF: o_seg = SEG_F[6:0];
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scanner with anti-ghost guard interval.
// Define FND_DOT_BLINK_EN to gate decimal points with a tick-driven blink.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int GUARD_CYCLES = 16
`ifdef FND_DOT_BLINK_EN
    , parameter int BLINK_TICKS = 500
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    input  logic [3:0]  i_blank,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data
);

    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    state_e         state_q;
    logic [1:0]     idx_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     com_q;
    logic [7:0]     data_q;

    logic [3:0]     code;
    logic [6:0]     seg;
    logic           blink_on;
    logic           dp_on;
    logic [7:0]     data_d;
    logic [3:0]     com_d;

    assign code = i_digits[{idx_q, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .i_code (code),
        .o_seg  (seg)
    );

`ifdef FND_DOT_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_TICKS - 1);

    logic [BW-1:0] bcnt_q;
    logic          blink_q;

    // Ticks are counted regardless of scan state so the blink rate is steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else if (i_tick) begin
            if (bcnt_q == BLAST) begin
                bcnt_q  <= '0;
                blink_q <= ~blink_q;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

    assign blink_on = blink_q;
`else
    assign blink_on = 1'b1;
`endif

    assign dp_on  = i_dp[idx_q] & blink_on;
    assign data_d = {~dp_on, i_blank[idx_q] ? 7'h7F : seg};
    assign com_d  = com_sel(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SHOW;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            com_q   <= COM_OFF;
            data_q  <= SEG_OFF;
        end else begin
            unique case (state_q)
                SHOW: begin
                    com_q  <= com_d;
                    data_q <= data_d;
                    if (i_tick) begin
                        idx_q <= idx_q + 2'd1;
                        if (GUARD_CYCLES > 0) begin
                            state_q <= GUARD;
                            cnt_q   <= '0;
                            com_q   <= COM_OFF;
                            data_q  <= SEG_OFF;
                        end
                    end
                end
                GUARD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= SHOW;
                        com_q   <= com_d;
                        data_q  <= data_d;
                    end
                end
            endcase
        end
    end

    assign o_fnd_com  = com_q;
    assign o_fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized bench for fnd_scan_ctrl against a digit-level display model.
// Covers FND_DOT_BLINK_EN when the macro is defined for the build.
module tb_fnd_scan_ctrl;

    localparam int GUARD = 16;
    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tick;
    logic [15:0] i_digits;
    logic [3:0]  i_dp;
    logic [3:0]  i_blank;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_data;

    int checks = 0;
    int errors = 0;
    int m_idx  = 0;
    int m_ticks = 0;

    logic [7:0] glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .GUARD_CYCLES (GUARD)
`ifdef FND_DOT_BLINK_EN
        , .BLINK_TICKS (BLINK)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (i_tick),
        .i_digits   (i_digits),
        .i_dp       (i_dp),
        .i_blank    (i_blank),
        .o_fnd_com  (o_fnd_com),
        .o_fnd_data (o_fnd_data)
    );

    function automatic logic [3:0] exp_com(int idx);
        logic [3:0] c;
        c = 4'hF;
        c[idx] = 1'b0;
        return c;
    endfunction

    function automatic logic [7:0] exp_data(int idx);
        logic [3:0] d;
        logic [6:0] s;
        logic       blink;
        d = i_digits[idx*4 +: 4];
`ifdef FND_DOT_BLINK_EN
        blink = ((m_ticks / BLINK) % 2) == 1;
`else
        blink = 1'b1;
`endif
        s = i_blank[idx] ? 7'h7F : glyph[d][6:0];
        return {~(i_dp[idx] & blink), s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        m_ticks++;
    endtask

    task automatic measure_guard(output int n);
        n = 0;
        while (o_fnd_com == 4'hF && o_fnd_data == 8'hFF && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic check_show(string name);
        checks++;
        if (o_fnd_com !== exp_com(m_idx) || o_fnd_data !== exp_data(m_idx)) begin
            errors++;
            $display("FAIL %s: com=%b data=%h, want com=%b data=%h",
                     name, o_fnd_com, o_fnd_data,
                     exp_com(m_idx), exp_data(m_idx));
        end
    endtask

    task automatic check_off(string name);
        checks++;
        if (o_fnd_com !== 4'hF || o_fnd_data !== 8'hFF) begin
            errors++;
            $display("FAIL %s: com=%b data=%h, want com=1111 data=ff",
                     name, o_fnd_com, o_fnd_data);
        end
    endtask

    task automatic check_len(string name, int n);
        checks++;
        if (n !== GUARD) begin
            errors++;
            $display("FAIL %s: guard=%0d clks, want %0d", name, n, GUARD);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_tick = 1'b0;
        i_digits = 16'h1234;
        i_dp = 4'h0;
        i_blank = 4'h0;
        step();
        step();
        check_off("reset_state");
        rst = 1'b0;
        m_idx = 0;
        m_ticks = 0;
        step();
        step();
        check_show("after_reset");
        checks++;
        if (o_fnd_data !== 8'h99 || o_fnd_com !== 4'b1110) begin
            errors++;
            $display("FAIL reset_digit0: com=%b data=%h, want 1110/99",
                     o_fnd_com, o_fnd_data);
        end
    endtask

    task automatic test_guard_timing();
        int n;
        pulse_tick();
        measure_guard(n);
        check_len("guard_len", n);
        m_idx = (m_idx + 1) % 4;
        check_show("after_guard");
    endtask

    task automatic test_wrap();
        int n;
        i_digits = 16'h1234;
        i_dp = 4'h0;
        i_blank = 4'h0;
        for (int k = 0; k < 5; k++) begin
            pulse_tick();
            measure_guard(n);
            check_len("wrap_guard", n);
            m_idx = (m_idx + 1) % 4;
            check_show("wrap_digit");
        end
    endtask

    task automatic test_random_scan();
        int n;
        for (int k = 0; k < 12; k++) begin
            i_digits = 16'($urandom);
            i_dp = 4'($urandom);
            i_blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step();
            check_show("rand_latency");
            pulse_tick();
            measure_guard(n);
            check_len("rand_guard", n);
            m_idx = (m_idx + 1) % 4;
            check_show("rand_next");
        end
    endtask

    task automatic test_blank();
        int n;
        for (int k = 0; k < 4 && m_idx != 0; k++) begin
            pulse_tick();
            measure_guard(n);
            m_idx = (m_idx + 1) % 4;
        end
        i_digits = 16'h5678;
        i_blank = 4'b0001;
        i_dp = 4'b0001;
        step();
        check_show("blank_dp");
`ifndef FND_DOT_BLINK_EN
        checks++;
        if (o_fnd_data !== 8'h7F || o_fnd_com !== 4'b1110) begin
            errors++;
            $display("FAIL blank_const: com=%b data=%h, want 1110/7f",
                     o_fnd_com, o_fnd_data);
        end
`endif
        i_blank = 4'h0;
        i_dp = 4'h0;
    endtask

    task automatic test_tick_in_guard();
        int n;
        pulse_tick();
        n = 0;
        while (o_fnd_com == 4'hF && o_fnd_data == 8'hFF && n < 64) begin
            i_tick = (n == 5);
            if (n == 5) m_ticks++;
            n++;
            step();
        end
        i_tick = 1'b0;
        check_len("guard_tick_len", n);
        m_idx = (m_idx + 1) % 4;
        check_show("guard_tick_idx");
        for (int k = 0; k < 4; k++) begin
            step();
            check_show("no_queued_tick");
        end
    endtask

    task automatic test_reset_mid();
        pulse_tick();
        step();
        step();
        rst = 1'b1;
        #1;
        check_off("rst_mid_guard");
        step();
        rst = 1'b0;
        m_idx = 0;
        m_ticks = 0;
        step();
        step();
        check_show("rst_guard_idx0");
        pulse_tick();
        begin
            int n;
            measure_guard(n);
        end
        m_idx = 1;
        step();
        check_show("show_idx1");
        rst = 1'b1;
        #1;
        check_off("rst_mid_show");
        step();
        rst = 1'b0;
        m_idx = 0;
        m_ticks = 0;
        step();
        step();
        check_show("rst_show_idx0");
    endtask

`ifdef FND_DOT_BLINK_EN
    task automatic test_blink();
        int n;
        i_dp = 4'hF;
        i_blank = 4'h0;
        for (int k = 0; k < 10; k++) begin
            pulse_tick();
            measure_guard(n);
            m_idx = (m_idx + 1) % 4;
            check_show("blink_dp");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_guard_timing();
        test_wrap();
        test_random_scan();
        test_blank();
        test_tick_in_guard();
        test_reset_mid();
`ifdef FND_DOT_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Consumer end of the FND watch digit path.
- Takes four 4-bit digit codes plus a 1 kHz scan tick, time-multiplexes them onto a 4-digit common-anode 7-segment display, and decodes each digit to segment patterns.
- Inserts a programmable all-off guard interval at every digit switch to suppress ghosting.
- Sits between the watch/stopwatch digit-select logic and the board FND pins.

Parameters:
- GUARD_CYCLES, 16, clk cycles all segments/commons held off after each digit switch; 0 disables the guard; must be less than the tick period.
- BLINK_TICKS, 500, ticks per decimal-point blink half-period (used only with FND_DOT_BLINK_EN).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- i_tick  input  1  one-clk-wide scan pulse, nominally 1 kHz
- i_digits  input  16  digit codes; [3:0]=digit0 (rightmost) ... [15:12]=digit3
- i_dp  input  4  decimal point request per digit, active-high
- i_blank  input  4  per-digit forced blank, active-high
- o_fnd_com  output  4  digit commons, active-low, one-hot-low while showing
- o_fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset: o_fnd_com=4'b1111, o_fnd_data=8'hFF, digit index=0, state=SHOW, guard counter=0, blink flag=0.
- All outputs are registered; a change on i_digits, i_dp or i_blank appears on o_fnd_data 1 clk later, in SHOW only.
- State SHOW:
  - o_fnd_com has bit [idx] low and all other bits high.
  - o_fnd_data=decode(i_digits[idx*4+:4]), with dp driven from i_dp[idx].
  - i_tick: idx<=idx+1 (2-bit, wraps 3->0).
    - If GUARD_CYCLES>0: state<=GUARD, counter<=0, outputs<=all off (com=4'hF, data=8'hFF) on that same edge.
    - If GUARD_CYCLES==0: SHOW continues directly with the new idx on the next edge.
- State GUARD:
  - Outputs are held all off and the counter increments each clk.
  - When counter==GUARD_CYCLES-1: state<=SHOW; the new digit is driven on that edge.
  - i_tick is ignored in GUARD and is not queued.
- Decode: 0-9 standard glyphs; 10-15 hex glyphs A,b,C,d,E,F.
- i_blank[idx]=1: segments a-g off; dp still follows i_dp[idx]; com still asserted.
- Reset asserted mid-GUARD or mid-SHOW: outputs go to the reset values immediately (asynchronous).

Optional Feature:
- Macro: FND_DOT_BLINK_EN.
  - Defined: an internal tick counter toggles the blink flag every BLINK_TICKS ticks. Ticks are counted in both states. A digit's dp is lit only when i_dp[n]=1 and the blink flag=1 (1 Hz blink at default settings).
  - Undefined: the counter and flag are not present; dp=i_dp[n] directly.

Decomposition:
- Shared package fnd_pkg:
  - state encoding SHOW/GUARD;
  - segment glyph constants SEG_0..SEG_F and SEG_OFF=8'hFF;
  - COM_OFF=4'b1111.
- One sub-module: bcd_to_seg (4-bit code in, 7-bit active-low segments out, combinational), instantiated once.

Test Plan:
1. Reset release, i_digits=16'h1234, no tick -> com=4'b1110, data=SEG_4 (8'h99) from the second clk after release.
2. GUARD_CYCLES=16, pulse i_tick -> next edge com=4'hF/data=8'hFF for exactly 16 clks, then com=4'b1101, data=SEG_3 (8'hB0).
3. Four ticks with a full guard between each -> com sequence 1110,1101,1011,0111,1110 (idx wrap); digits 4,3,2,1,4.
4. i_blank=4'b0001, i_dp=4'b0001, i_digits[3:0]=4'h8 -> digit0 data=8'h7F (segments off, dp on).
5. i_tick asserted during GUARD -> ignored: idx advances by exactly 1 per SHOW-state tick; GUARD length unchanged.
6. Assert rst mid-GUARD for 1 clk -> outputs 4'hF/8'hFF immediately; after release idx=0. With FND_DOT_BLINK_EN and BLINK_TICKS=4 -> dp toggles every 4 ticks.
